// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read-port register file with byte-masked
// writes, optional hardwired-zero r0, optional write-to-read bypass and a
// post-reset clear sequencer that zeroes the array one entry per cycle.

// Per-port read formatter: selects stored word, bypass merge, or forced zero.
module regfile_mp_rd #(
  parameter int DATA_W = 32
) (
  input  logic              i_kill,
  input  logic              i_byp,
  input  logic [DATA_W-1:0] i_mem,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] i_wmask,
  output logic [DATA_W-1:0] o_data
);
  // Kill dominates (not ready / zero register); bypass merges enabled bytes.
  always_comb begin
    o_data = i_mem;
    if (i_byp)  o_data = (i_wdata & i_wmask) | (i_mem & ~i_wmask);
    if (i_kill) o_data = '0;
  end
endmodule

module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] ReadReg,
  output logic [NUM_RD*DATA_W-1:0] ReadData,
  input  logic                     RegWrite,
  input  logic [ADDR_W-1:0]        WriteReg,
  input  logic [DATA_W-1:0]        WriteData,
  input  logic [DATA_W/8-1:0]      WriteByteEn,
  output logic                     Ready,
  output logic                     WriteDropped
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int NBYTE = DATA_W / 8;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_clr_idx;
  logic              r_wdrop;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] w_wmask;
  logic              w_last;
  logic              w_wr_en;

  assign w_last       = (r_clr_idx == '1);
  assign Ready        = (r_state == RUN);
  assign WriteDropped = r_wdrop;
  // Writes to the hardwired zero register are silently ignored, not flagged.
  assign w_wr_en      = RegWrite && !((ZERO_REG != 0) && (WriteReg == '0));

  // Expand byte enables into a bit mask shared by the write path and bypass.
  always_comb begin
    w_wmask = '0;
    for (int b = 0; b < NBYTE; b++) w_wmask[b*8 +: 8] = {8{WriteByteEn[b]}};
  end

  // Next state: CLEAR hands over to RUN after clearing the last entry.
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == CLEAR && w_last) w_state_nxt = RUN;
  end

  // Sequencer state, clear counter and dropped-write pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= CLEAR;
      r_clr_idx <= '0;
      r_wdrop   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      if (r_state == CLEAR) r_clr_idx <= r_clr_idx + 1'b1;
      r_wdrop   <= (r_state == CLEAR) && RegWrite;
    end
  end

  // Array has no reset; the sequencer clear always wins over user writes.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (r_state == CLEAR) begin
        r_mem[r_clr_idx] <= '0;
      end else if (w_wr_en) begin
        for (int b = 0; b < NBYTE; b++)
          if (WriteByteEn[b]) r_mem[WriteReg][b*8 +: 8] <= WriteData[b*8 +: 8];
      end
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic              w_zero;
    logic              w_kill;
    logic              w_byp;

    assign w_ra   = ReadReg[g*ADDR_W +: ADDR_W];
    assign w_zero = (ZERO_REG != 0) && (w_ra == '0);
    assign w_kill = !Ready || w_zero;
    assign w_byp  = (BYPASS != 0) && Ready && RegWrite && (WriteReg == w_ra) && !w_zero;

    regfile_mp_rd #(.DATA_W(DATA_W)) u_rd (
      .i_kill  (w_kill),
      .i_byp   (w_byp),
      .i_mem   (r_mem[w_ra]),
      .i_wdata (WriteData),
      .i_wmask (w_wmask),
      .o_data  (ReadData[g*DATA_W +: DATA_W])
    );
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default 32x32/2-port instance (A) and a
// 8x64/4-port no-bypass instance (B).
module tb_regfile_mp;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance A: defaults
  logic        a_rst, a_we, a_rdy, a_drop;
  logic [9:0]  a_rr;
  logic [63:0] a_rd;
  logic [4:0]  a_wr;
  logic [31:0] a_wd;
  logic [3:0]  a_be;

  regfile_mp u_a (
    .clock(clk), .reset(a_rst), .ReadReg(a_rr), .ReadData(a_rd),
    .RegWrite(a_we), .WriteReg(a_wr), .WriteData(a_wd), .WriteByteEn(a_be),
    .Ready(a_rdy), .WriteDropped(a_drop)
  );

  // Instance B: 4 ports, 64-bit, 8 entries, no bypass
  logic         b_rst, b_we, b_rdy, b_drop;
  logic [11:0]  b_rr;
  logic [255:0] b_rd;
  logic [2:0]   b_wr;
  logic [63:0]  b_wd;
  logic [7:0]   b_be;

  regfile_mp #(.DATA_W(64), .ADDR_W(3), .NUM_RD(4), .ZERO_REG(1), .BYPASS(0)) u_b (
    .clock(clk), .reset(b_rst), .ReadReg(b_rr), .ReadData(b_rd),
    .RegWrite(b_we), .WriteReg(b_wr), .WriteData(b_wd), .WriteByteEn(b_be),
    .Ready(b_rdy), .WriteDropped(b_drop)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int n;

  initial begin
    a_rst = 1'b1; a_we = 1'b0; a_rr = '0; a_wr = '0; a_wd = '0; a_be = '0;
    b_rst = 1'b1; b_we = 1'b0; b_rr = '0; b_wr = '0; b_wd = '0; b_be = '0;
    tick(); tick();
    chk("a_rst_ready", a_rdy, 0);
    chk("a_rst_drop",  a_drop, 0);
    chk("a_rst_rd",    a_rd, 0);

    // Bring A up and preload a few entries with a recognisable pattern
    a_rst = 1'b0;
    n = 0;
    while (!a_rdy && n < 100) begin tick(); n++; end
    chk("a_first_clear_len", n, 32);
    a_we = 1'b1; a_wd = 32'hDEADBEEF; a_be = 4'hF;
    a_wr = 5'd4;  tick();
    a_wr = 5'd9;  tick();
    a_wr = 5'd31; tick();
    a_wr = 5'd3;  tick();
    a_we = 1'b0;
    a_rr = {5'd31, 5'd4};
    #1 chk("a_preload_rd", a_rd, {32'hDEADBEEF, 32'hDEADBEEF});

    // Reset for 2 cycles; data is unreadable while not ready
    a_rst = 1'b1; tick(); tick();
    chk("a_rst2_ready", a_rdy, 0);
    chk("a_rst2_rd_hidden", a_rd, 0);
    a_rst = 1'b0;
    n = 0;
    while (!a_rdy && n < 100) begin
      if (n == 10) begin
        a_we = 1'b1; a_wr = 5'd3; a_wd = 32'h55; a_be = 4'hF;
      end
      tick(); n++;
      a_we = 1'b0;
      if (n == 11) chk("a_drop_pulse", a_drop, 1);
      if (n == 12) chk("a_drop_clear", a_drop, 0);
    end
    chk("a_clear_len", n, 32);
    for (int i = 0; i < 32; i++) begin
      a_rr = {5'(31 - i), 5'(i)};
      #1 chk($sformatf("a_cleared_r%0d", i), a_rd, 0);
    end

    // Byte-masked writes and bypass on r5
    a_we = 1'b1; a_wr = 5'd5; a_wd = 32'h12345678; a_be = 4'b1111;
    tick();
    a_rr = {5'd5, 5'd5};
    a_wd = 32'hAABBCCDD; a_be = 4'b0101;
    #1 chk("a_bypass_r5", a_rd, {32'h12BB56DD, 32'h12BB56DD});
    tick();
    a_we = 1'b0;
    #1 chk("a_r5_merged", a_rd, {32'h12BB56DD, 32'h12BB56DD});

    // Zero register ignores writes, no bypass, no drop flag
    a_we = 1'b1; a_wr = 5'd0; a_wd = 32'hFFFFFFFF; a_be = 4'hF; a_rr = {5'd0, 5'd0};
    #1 chk("a_r0_bypass", a_rd, 0);
    tick();
    a_we = 1'b0;
    chk("a_r0_rd", a_rd, 0);
    chk("a_r0_drop", a_drop, 0);

    // Reset in RUN wipes r7
    a_we = 1'b1; a_wr = 5'd7; a_wd = 32'h99; a_be = 4'hF;
    tick();
    a_we = 1'b0; a_rr = {5'd7, 5'd7};
    #1 chk("a_r7_written", a_rd, {32'h99, 32'h99});
    a_rst = 1'b1; tick();
    chk("a_run_rst_ready", a_rdy, 0);
    chk("a_run_rst_rd", a_rd, 0);
    a_rst = 1'b0;
    n = 0;
    while (!a_rdy && n < 100) begin tick(); n++; end
    chk("a_reclear_len", n, 32);
    chk("a_r7_cleared", a_rd, 0);

    // Instance B: 8-entry clear, no bypass, visible after the edge
    b_rst = 1'b0;
    n = 0;
    while (!b_rdy && n < 100) begin tick(); n++; end
    chk("b_clear_len", n, 8);
    b_rr = {3'd2, 3'd2, 3'd2, 3'd2};
    b_we = 1'b1; b_wr = 3'd2; b_wd = 64'h0123456789ABCDEF; b_be = 8'hFF;
    #1 chk("b_pre_edge", b_rd[127:0], 0);
    chk("b_pre_edge_hi", b_rd[255:128], 0);
    tick();
    b_we = 1'b0;
    for (int p = 0; p < 4; p++)
      chk($sformatf("b_port%0d", p), b_rd[p*64 +: 64], 64'h0123456789ABCDEF);
    chk("b_drop", b_drop, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
